// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub -- digit-serial subtractor / comparator
//
// Computes d0 - d1 - bIn one DIGIT-bit slice per clock, least significant slice
// first, with the borrow carried between slices in an internal register. All
// operands and control bits are captured when a request is accepted. The visible
// results change only when an operation completes, so partial differences are
// never exposed.
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous active-high reset (aborts any operation in flight)
//   start     request, accepted only while ready=1
//   d0, d1    minuend / subtrahend (WIDTH bits)
//   bIn       borrow-in
//   enable    result gate: dOut forced to zero when low
//   mode      0 = subtract (dOut valid), 1 = compare (dOut forced to zero)
//   ready     high while idle and able to accept a request
//   done      one-cycle pulse in the cycle the results update
//   dOut      difference, gated by enable and mode
//   bOut      borrow out of the most significant bit
//   zero      unmasked difference equals zero
//   overflow  two's-complement overflow of the subtraction
// -----------------------------------------------------------------------------
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             bIn,
    input  logic             enable,
    input  logic             mode,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] dOut,
    output logic             bOut,
    output logic             zero,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    // A single-step configuration still needs a 1-bit counter.
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Captured request
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             en_reg;
    logic             mode_reg;

    // Serial datapath state
    logic             borrow_reg;
    logic [CNT_W-1:0] step_reg;
    logic [DIGIT-1:0] res_reg [STEPS];

    // Visible results
    logic [WIDTH-1:0] dout_reg;
    logic             bout_reg;
    logic             zero_reg;
    logic             ovf_reg;

    // Combinational helpers
    logic [DIGIT-1:0] a_sl [STEPS];
    logic [DIGIT-1:0] b_sl [STEPS];
    logic [DIGIT-1:0] a_digit;
    logic [DIGIT-1:0] b_digit;
    logic [DIGIT:0]   digit_sum;
    logic [DIGIT-1:0] diff_digit;
    logic             borrow_next;
    logic [WIDTH-1:0] raw_next;
    logic             last_step;
    logic             accept;

    // Split the captured operands into slices, and assemble the full difference
    // as it will stand once the current slice is written. Only the value seen on
    // the last step is ever used, when every lower slice is already fresh.
    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_slice
            assign a_sl[gi] = a_reg[gi*DIGIT +: DIGIT];
            assign b_sl[gi] = b_reg[gi*DIGIT +: DIGIT];
            assign raw_next[gi*DIGIT +: DIGIT] =
                (step_reg == CNT_W'(gi)) ? diff_digit : res_reg[gi];
        end
    endgenerate

    always_comb begin
        a_digit     = a_sl[step_reg];
        b_digit     = b_sl[step_reg];
        // One extra bit catches the borrow: it is set whenever the slice
        // difference goes negative.
        digit_sum   = {1'b0, a_digit} - {1'b0, b_digit} - {{DIGIT{1'b0}}, borrow_reg};
        diff_digit  = digit_sum[DIGIT-1:0];
        borrow_next = digit_sum[DIGIT];
        last_step   = (step_reg == LAST_STEP);
        accept      = (state_reg == IDLE) && start;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Control and visible results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            step_reg   <= '0;
            borrow_reg <= 1'b0;
            dout_reg   <= '0;
            bout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                step_reg   <= '0;
                borrow_reg <= bIn;
            end else if (state_reg == RUN) begin
                step_reg   <= step_reg + CNT_W'(1);
                borrow_reg <= borrow_next;
                if (last_step) begin
                    dout_reg <= (en_reg && !mode_reg) ? raw_next : '0;
                    bout_reg <= borrow_next;
                    zero_reg <= (raw_next == '0);
                    ovf_reg  <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) &
                                (raw_next[WIDTH-1] ^ a_reg[WIDTH-1]);
                end
            end
        end
    end

    // Operand capture and partial-difference storage; contents are only
    // meaningful inside an operation, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg    <= d0;
            b_reg    <= d1;
            en_reg   <= enable;
            mode_reg <= mode;
        end
        if (state_reg == RUN) begin
            res_reg[step_reg] <= diff_digit;
        end
    end

    assign ready    = (state_reg == IDLE);
    assign done     = (state_reg == DONE);
    assign dOut     = dout_reg;
    assign bOut     = bout_reg;
    assign zero     = zero_reg;
    assign overflow = ovf_reg;

endmodule
